// File: rtl/ps2_cmd_sched.sv
// PS/2 host-to-keyboard command scheduler: two-requester arbitration, transmit framing, response handling.
// Optional PS2_CMD_TIMEOUT_EN adds a no-progress abort in SEND and WAIT_RESP.
module ps2_cmd_sched #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] req,
  input  logic [7:0] cmd0,
  input  logic [7:0] cmd1,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       busy,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_inhibit
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, WAIT_RESP, DONE, FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      clk_sync_q;
  logic [1:0]      dat_sync_q;
  logic            fall, dat_s;
  logic            rr_q, rr_d;
  logic            gnt_q, gnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [3:0]      idx_q, idx_d;
  logic            dat_q, dat_d;

`ifdef PS2_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]   to_q, to_d;
  logic            to_expired;
  assign to_expired = (to_q == '0);
`endif

  // [0],[1] synchronise; [2] holds the previous synchronised clock level
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
  end

  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      gnt_q   <= 1'b0;
      cmd_q   <= '0;
      inh_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      dat_q   <= 1'b0;
`ifdef PS2_CMD_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      inh_q   <= inh_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
`ifdef PS2_CMD_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    inh_d   = inh_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
`ifdef PS2_CMD_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // rr only moves on contention, so a lone request never disturbs fairness
          if (req == 2'b11) begin
            gnt_d = ~rr_q;
            rr_d  = ~rr_q;
          end else begin
            gnt_d = req[1];
          end
          cmd_d   = gnt_d ? cmd1 : cmd0;
          inh_d   = IW'(INHIBIT_CYC - 1);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == '0) begin
          state_d = RTS;
        end else begin
          inh_d = inh_q - IW'(1);
        end
      end
      RTS: begin
        idx_d   = '0;
        dat_d   = 1'b1;
        state_d = SEND;
`ifdef PS2_CMD_TIMEOUT_EN
        to_d    = TW'(TIMEOUT_CYC);
`endif
      end
      SEND: begin
        if (fall) begin
          idx_d = idx_q + 4'd1;
`ifdef PS2_CMD_TIMEOUT_EN
          to_d  = TW'(TIMEOUT_CYC);
`endif
          if (idx_q < 4'd8) begin
            dat_d = ~cmd_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            dat_d = ^cmd_q;
          end else if (idx_q == 4'd9) begin
            dat_d = 1'b0;
          end else begin
            state_d = dat_s ? FAIL : WAIT_RESP;
          end
        end
`ifdef PS2_CMD_TIMEOUT_EN
        else if (to_expired) begin
          state_d = FAIL;
        end else begin
          to_d = to_q - TW'(1);
        end
`endif
      end
      WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_data == 8'hFA) begin
            state_d = DONE;
          end else if (rx_data == 8'hFE && retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            inh_d   = IW'(INHIBIT_CYC - 1);
            state_d = INHIBIT;
          end else begin
            state_d = FAIL;
          end
        end
`ifdef PS2_CMD_TIMEOUT_EN
        else if (to_expired) begin
          state_d = FAIL;
        end else begin
          to_d = to_q - TW'(1);
        end
`endif
      end
      DONE, FAIL: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_CMD_TIMEOUT_EN
    if (state_d == WAIT_RESP && state_q == SEND) begin
      to_d = TW'(TIMEOUT_CYC);
    end
`endif
  end

  always_comb begin
    done = '0;
    err  = '0;
    if (state_q == DONE) done[gnt_q] = 1'b1;
    if (state_q == FAIL) err[gnt_q]  = 1'b1;
  end

  assign busy       = (state_q != IDLE);
  assign ps2_clk_oe = (state_q == INHIBIT);
  assign ps2_dat_oe = (state_q == RTS) | ((state_q == SEND) & dat_q);
  assign rx_inhibit = (state_q == INHIBIT) | (state_q == RTS) | (state_q == SEND);

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Directed bench for ps2_cmd_sched with an open-drain PS/2 keyboard model.
module tb_ps2_cmd_sched;

  localparam int INH  = 300;
  localparam int HALF = 10;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [1:0] req;
  logic [7:0] cmd0, cmd1;
  logic [1:0] done, err;
  logic       busy;
  logic       PS2_CLK, PS2_DAT;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_inhibit;
  logic       dev_clk, dev_dat;

  int errors, checks;
  int done0_n, done1_n, err0_n, err1_n;

  assign PS2_CLK = ~ps2_clk_oe & dev_clk;
  assign PS2_DAT = ~ps2_dat_oe & dev_dat;

  ps2_cmd_sched #(.INHIBIT_CYC(INH)) u_dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .req       (req),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_inhibit(rx_inhibit)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    done0_n = 0; done1_n = 0; err0_n = 0; err1_n = 0;
  end

  always @(negedge CLOCK_50) begin
    if (done[0]) done0_n <= done0_n + 1;
    if (done[1]) done1_n <= done1_n + 1;
    if (err[0])  err0_n  <= err0_n + 1;
    if (err[1])  err1_n  <= err1_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Keyboard side of one transmit: waits out the inhibit, clocks nfalls falls,
  // captures the 10 bits after the start bit, and drops req on an err pulse at fall 11.
  task automatic dev_frame(input logic ack, input int nfalls,
                           output logic [9:0] bits, output logic [1:0] err_seen);
    int n;
    logic s;
    bits     = '0;
    err_seen = '0;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin cyc(1); n++; end
    chk("inhibit_start", ps2_clk_oe, 1);
    chk("rx_inhibit_tx", rx_inhibit, 1);
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin cyc(1); n++; end
    chk("inhibit_len", n, INH);
    chk("start_bit_oe", ps2_dat_oe, 1);
    cyc(4);
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10 && ack) begin dev_dat = 1'b0; cyc(2); end
      dev_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        cyc(1);
        if (err != 2'b00) begin err_seen = err; req = req & ~err; end
      end
      s = PS2_DAT;
      if (i < 10) bits[i] = s;
      dev_clk = 1'b1;
      cyc(HALF);
      dev_dat = 1'b1;
    end
  endtask

  task automatic respond(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  initial begin
    logic [9:0] bits;
    logic [1:0] es;
    errors = 0; checks = 0;
    RESET_N = 1'b0; req = '0; cmd0 = 8'hED; cmd1 = '0;
    rx_valid = 1'b0; rx_data = '0; dev_clk = 1'b1; dev_dat = 1'b1;
    cyc(3);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    RESET_N = 1'b1;
    cyc(2);

    // single request, 0xED -> bits 1,0,1,1,0,1,1,1 parity 1 stop 1
    req = 2'b01;
    dev_frame(1'b1, 11, bits, es);
    chk("t1_bits", bits, 10'h3ED);
    chk("t1_wait_rx_inhibit", rx_inhibit, 0);
    chk("t1_wait_busy", busy, 1);
    chk("t1_done_pre", done, 0);
    respond(8'hFA);
    chk("t1_done", done, 2'b01);
    chk("t1_err", err, 0);
    req = 2'b00;
    cyc(1);
    chk("t1_done_width", done, 0);
    chk("t1_busy_idle", busy, 0);

    // contention from reset: 0xF4 (five ones -> parity 0) then 0xED
    RESET_N = 1'b0; req = 2'b11; cmd0 = 8'hF4; cmd1 = 8'hED;
    cyc(2);
    RESET_N = 1'b1;
    dev_frame(1'b1, 11, bits, es);
    chk("t2a_bits", bits, 10'h2F4);
    respond(8'hFA);
    chk("t2a_done", done, 2'b01);
    req = 2'b10;
    cyc(1);
    chk("t2a_idle_gap", busy, 0);
    cyc(1);
    chk("t2a_regrant", busy, 1);
    dev_frame(1'b1, 11, bits, es);
    chk("t2b_bits", bits, 10'h3ED);
    respond(8'hFA);
    chk("t2b_done", done, 2'b10);
    req = 2'b00;
    cyc(1);
    req = 2'b11;
    dev_frame(1'b1, 11, bits, es);
    chk("t2c_bits", bits, 10'h3ED);
    respond(8'hFA);
    chk("t2c_done", done, 2'b10);
    req = 2'b01;
    cyc(1);
    chk("t2d_idle_gap", busy, 0);
    cyc(1);
    dev_frame(1'b1, 11, bits, es);
    chk("t2d_bits", bits, 10'h2F4);
    respond(8'hFA);
    chk("t2d_done", done, 2'b01);
    req = 2'b00;
    cyc(1);

    // resend twice then accept, 0xF3 has six ones -> parity 1
    cmd1 = 8'hF3; req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      dev_frame(1'b1, 11, bits, es);
      chk("t3_bits", bits, 10'h3F3);
      if (k < 2) begin
        respond(8'hFE);
        chk("t3_no_err", err, 0);
        chk("t3_no_done", done, 0);
      end else begin
        respond(8'hFA);
        chk("t3_done", done, 2'b10);
      end
    end
    req = 2'b00;
    cyc(1);

    // retry exhaustion, 0x55 has four ones -> parity 1
    cmd0 = 8'h55; req = 2'b01;
    for (int k = 0; k < 4; k++) begin
      dev_frame(1'b1, 11, bits, es);
      chk("t4_bits", bits, 10'h355);
      respond(8'hFE);
      chk("t4_err", err, (k == 3) ? 2'b01 : 2'b00);
    end
    chk("t4_clk_oe", ps2_clk_oe, 0);
    chk("t4_dat_oe", ps2_dat_oe, 0);
    req = 2'b00;
    cyc(2);
    chk("t4_no_more_frames", busy, 0);

    // missing line ACK, 0x00 -> parity 1
    cmd0 = 8'h00; req = 2'b01;
    dev_frame(1'b0, 11, bits, es);
    chk("t5_bits", bits, 10'h300);
    chk("t5_err", es, 2'b01);
    chk("t5_idle", busy, 0);
    respond(8'hFA);
    chk("t5_no_done", done, 0);

    // reset after fall 5 of 0xED: bit 4 is 0 so the data line is held low
    cmd0 = 8'hED; req = 2'b01;
    dev_frame(1'b1, 5, bits, es);
    chk("t6_dat_low_pre", ps2_dat_oe, 1);
    RESET_N = 1'b0;
    #1;
    chk("t6_clk_oe", ps2_clk_oe, 0);
    chk("t6_dat_oe", ps2_dat_oe, 0);
    chk("t6_busy", busy, 0);
    req = 2'b00;
    cyc(3);
    RESET_N = 1'b1;
    cyc(20);

    chk("cnt_done0", done0_n, 3);
    chk("cnt_done1", done1_n, 3);
    chk("cnt_err0", err0_n, 2);
    chk("cnt_err1", err1_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
